// File: rtl/b32to128_gearbox_pkg.sv
// Shared widths and helpers for the 32-bit to 128-bit datapath gearbox.
package b32to128_gearbox_pkg;
  localparam int WORD_W        = 32;
  localparam int BLOCK_W       = 128;
  localparam int RATIO_DEFAULT = BLOCK_W / WORD_W;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int clog2w(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/b32to128_gearbox.sv
// Packs RATIO consecutive IN_W-bit words into one block, with handshakes,
// short-block termination (zero padded) and selectable word order.
module b32to128_gearbox
  import b32to128_gearbox_pkg::*;
#(
  parameter int IN_W      = WORD_W,
  parameter int RATIO     = RATIO_DEFAULT,
  parameter int MSW_FIRST = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IN_W-1:0]                 in_data,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [RATIO*IN_W-1:0]           out_data,
  output logic [clog2w(RATIO+1)-1:0]      out_count
);
  localparam int CW = clog2w(RATIO + 1);

  logic [RATIO-1:0][IN_W-1:0] acc_q, acc_d, merged;
  logic [CW-1:0]              cnt_q, cnt_d, slot;
  logic [RATIO*IN_W-1:0]      out_data_q, out_data_d;
  logic [CW-1:0]              out_count_q, out_count_d;
  logic                       out_valid_q, out_valid_d;
  logic                       beat, drain, fin;

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign beat     = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;
  assign fin      = (cnt_q == CW'(RATIO - 1)) || in_last;
  assign slot     = (MSW_FIRST != 0) ? CW'(RATIO - 1) - cnt_q : cnt_q;

  always_comb begin
    for (int k = 0; k < RATIO; k++)
      merged[k] = (CW'(k) == slot) ? in_data : acc_q[k];
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    if (drain) out_valid_d = 1'b0;
    // flush forces in_ready low, so it never coincides with a beat
    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (beat) begin
      if (fin) begin
        out_data_d  = merged;
        out_count_d = cnt_q + CW'(1);
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
endmodule

// File: tb/tb_b32to128_gearbox.sv
// Scoreboard bench: both word orders run side by side on shared stimulus.
module tb_b32to128_gearbox;
  logic         clock = 0, reset = 1, flush = 0;
  logic         in_valid = 0, in_last = 0, out_ready = 1;
  logic [31:0]  in_data = 0;
  logic         d1_in_ready, d1_out_valid, d0_in_ready, d0_out_valid;
  logic [127:0] d1_out_data, d0_out_data;
  logic [2:0]   d1_out_count, d0_out_count;

  int total = 0, bad = 0;

  typedef struct {logic [127:0] d; logic [2:0] c;} blk_t;
  blk_t        q1[$], q0[$];
  blk_t        e1, e0;
  logic [31:0] m_words[$];

  always #5 clock = ~clock;

  b32to128_gearbox #(.IN_W(32), .RATIO(4), .MSW_FIRST(1)) d1 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(d1_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(d1_out_valid), .out_ready(out_ready),
    .out_data(d1_out_data), .out_count(d1_out_count));

  b32to128_gearbox #(.IN_W(32), .RATIO(4), .MSW_FIRST(0)) d0 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(d0_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(d0_out_valid), .out_ready(out_ready),
    .out_data(d0_out_data), .out_count(d0_out_count));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference packing: collected words go to slot 3-i (msw) or slot i (lsw).
  task automatic model_beat(input logic [31:0] d, input bit last);
    blk_t b1, b0;
    m_words.push_back(d);
    if (last || m_words.size() == 4) begin
      b1.d = '0; b0.d = '0;
      for (int i = 0; i < m_words.size(); i++) begin
        b1.d[(3-i)*32 +: 32] = m_words[i];
        b0.d[i*32 +: 32]     = m_words[i];
      end
      b1.c = 3'(m_words.size()); b0.c = b1.c;
      q1.push_back(b1); q0.push_back(b0);
      m_words.delete();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send(input logic [31:0] d, input bit last, output int waits);
    bit ok;
    waits = 0; ok = 0;
    in_valid = 1; in_data = d; in_last = last;
    forever begin
      @(negedge clock); ok = d1_in_ready;
      @(posedge clock); #1;
      if (ok) break;
      waits++;
      if (waits > 200) begin chk("send_timeout", 1, 0); break; end
    end
    if (ok) model_beat(d, last);
    in_valid = 0; in_last = 0; in_data = $urandom;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    q1.delete(); q0.delete(); m_words.delete();
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (d1_out_valid && out_ready) begin
        if (q1.size() == 0) chk("d1_extra_block", 1, 0);
        else begin
          e1 = q1.pop_front();
          chk("d1_data", d1_out_data, e1.d);
          chk("d1_count", 128'(d1_out_count), 128'(e1.c));
        end
      end
      if (d0_out_valid && out_ready) begin
        if (q0.size() == 0) chk("d0_extra_block", 1, 0);
        else begin
          e0 = q0.pop_front();
          chk("d0_data", d0_out_data, e0.d);
          chk("d0_count", 128'(d0_out_count), 128'(e0.c));
        end
      end
    end
  end

  initial begin
    int w, n;
    @(posedge clock); #1;
    do_reset();
    chk("rst_valid", 128'(d1_out_valid), 0);
    chk("rst_data", d1_out_data, 0);
    chk("rst_count", 128'(d1_out_count), 0);
    chk("rst_ready", 128'(d1_in_ready), 1);

    // 1/2: full block, both orders
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      send({4{4'(i)}} * 32'h1 | {8{4'(i)}}, 0, w);
      chk("t1_no_stall", 128'(w), 0);
    end
    chk("t1_valid", 128'(d1_out_valid), 1);
    chk("t1_msw", d1_out_data, 128'h11111111_22222222_33333333_44444444);
    chk("t2_lsw", d0_out_data, 128'h44444444_33333333_22222222_11111111);
    chk("t1_count", 128'(d1_out_count), 4);

    // 3: short block via in_last, then next block starts in slot 3
    send(32'hAAAA0001, 0, w);
    send(32'hAAAA0002, 1, w);
    chk("t3_msw", d1_out_data, 128'hAAAA0001_AAAA0002_00000000_00000000);
    chk("t3_lsw", d0_out_data, 128'h00000000_00000000_AAAA0002_AAAA0001);
    chk("t3_count", 128'(d1_out_count), 2);
    for (int i = 0; i < 4; i++) send(32'hB0000000 + i, 0, w);

    // 4: backpressure across two blocks
    @(posedge clock); #1;
    out_ready = 0;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(32'h40000000 + i, 0, w);
      end
      begin
        n = 0;
        while (!d1_out_valid && n < 50) begin @(negedge clock); n++; end
        chk("t4_block1_seen", 128'(d1_out_valid), 1);
        repeat (4) begin
          @(negedge clock);
          chk("t4_ready_low", 128'(d1_in_ready), 0);
          chk("t4_hold_valid", 128'(d1_out_valid), 1);
          chk("t4_hold_data", d1_out_data, 128'h40000001_40000002_40000003_40000004);
        end
        @(posedge clock); #1;
        out_ready = 1;
      end
    join
    repeat (3) @(posedge clock); #1;

    // 5: flush drops the concurrent word and any partial block
    send(32'h50000001, 0, w);
    send(32'h50000002, 0, w);
    flush = 1; in_valid = 1; in_data = 32'hDEADBEEF;
    @(negedge clock);
    chk("t5_flush_ready", 128'(d1_in_ready), 0);
    @(posedge clock); #1;
    flush = 0; in_valid = 0;
    m_words.delete();
    for (int i = 0; i < 4; i++) send(32'h5A000000 + i, 0, w);
    repeat (2) @(posedge clock); #1;

    // 6: reset mid-block with a previous block in the output register
    for (int i = 0; i < 7; i++) send(32'h60000000 + i, 0, w);
    do_reset();
    chk("t6_valid", 128'(d1_out_valid), 0);
    chk("t6_data", d1_out_data, 0);
    chk("t6_count", 128'(d1_out_count), 0);
    chk("t6_ready", 128'(d1_in_ready), 1);
    for (int i = 0; i < 4; i++) send(32'h70000000 + i, 0, w);
    repeat (3) @(posedge clock); #1;

    chk("sb_empty", 128'(q1.size() + q0.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
